// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered RISC-V immediate generator (I/S/B/U/J, optional Z)
//            with a valid/ready output stage and a one-entry skid buffer.
//            Optional CSR uimm path enabled by macro IMM_GEN_ZICSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            illegal
);

  localparam logic [2:0] c_SRC_I = 3'b000;
  localparam logic [2:0] c_SRC_S = 3'b001;
  localparam logic [2:0] c_SRC_B = 3'b010;
  localparam logic [2:0] c_SRC_U = 3'b011;
  localparam logic [2:0] c_SRC_J = 3'b100;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] c_SRC_Z = 3'b101;
`endif

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_sign;
  logic            w_unused;

  logic [XLEN-1:0] r_out_imm;
  logic            r_out_ill;
  logic            r_out_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_skid_ill;
  logic            r_skid_valid;

  logic            w_in_xfer;
  logic            w_out_free;

  assign w_sign   = instr[31];
  // Opcode bits never contribute to any immediate format.
  assign w_unused = ^instr[6:0];

  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (imm_src)
      c_SRC_I: w_imm32 = {{20{w_sign}}, instr[31:20]};
      c_SRC_S: w_imm32 = {{20{w_sign}}, instr[31:25], instr[11:7]};
      c_SRC_B: w_imm32 = {{19{w_sign}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      c_SRC_U: w_imm32 = {instr[31:12], 12'b0};
      c_SRC_J: w_imm32 = {{11{w_sign}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      c_SRC_Z: w_imm32 = {27'b0, instr[19:15]};
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Every 32-bit result is already correctly signed, so widening is a plain
  // replication of bit 31 (zero for Z and reserved selects).
  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_xlen_32
      assign w_imm = w_imm32;
    end
  endgenerate

  assign in_ready   = ~r_skid_valid;
  assign w_in_xfer  = in_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_imm    <= '0;
      r_out_ill    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A full skid implies in_ready was low, so nothing new is accepted here.
      if (r_skid_valid) begin
        r_out_imm    <= r_skid_imm;
        r_out_ill    <= r_skid_ill;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_imm   <= w_imm;
        r_out_ill   <= w_illegal;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_imm   <= w_imm;
      r_skid_ill   <= w_illegal;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign imm_ext   = r_out_imm;
  assign illegal   = r_out_ill;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed self-checking bench for imm_gen_pipe (XLEN 32 and 64).
//            Z-select expectations follow macro IMM_GEN_ZICSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] imm_ext;
  logic        illegal;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] imm_ext64;
  logic        illegal64;

  int n_err    = 0;
  int n_checks = 0;

  imm_gen_pipe #(.XLEN(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_ext   (imm_ext),
    .illegal   (illegal)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .instr     (instr),
    .imm_src   (imm_src),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .imm_ext   (imm_ext64),
    .illegal   (illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One item presented for exactly one cycle with out_ready high.
  task automatic send(input logic [31:0] ins, input logic [2:0] src);
    instr    = ins;
    imm_src  = src;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    imm_src   = '0;
    out_ready = 1'b1;
    tick();
    tick();

    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_imm_ext",   {32'b0, imm_ext},   64'd0);
    chk("rst_illegal",   {63'b0, illegal},   64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_imm_ext64", imm_ext64,          64'd0);

    rst = 1'b1;
    tick();
    chk("post_rst_idle", {63'b0, out_valid}, 64'd0);

    // Single items, latency one cycle.
    send(32'hFFF00093, 3'b000);
    chk("I_valid",  {63'b0, out_valid}, 64'd1);
    chk("I_imm",    {32'b0, imm_ext},   64'h0000_0000_FFFF_FFFF);
    chk("I_ill",    {63'b0, illegal},   64'd0);
    chk("I_imm64",  imm_ext64,          64'hFFFF_FFFF_FFFF_FFFF);

    send(32'hFE112E23, 3'b001);
    chk("S_imm",    {32'b0, imm_ext},   64'h0000_0000_FFFF_FFFC);

    send(32'hFE000EE3, 3'b010);
    chk("B_imm",    {32'b0, imm_ext},   64'h0000_0000_FFFF_FFFC);

    send(32'h0080006F, 3'b100);
    chk("J_imm",    {32'b0, imm_ext},   64'h0000_0000_0000_0008);

    send(32'h123450B7, 3'b011);
    chk("U_imm",    {32'b0, imm_ext},   64'h0000_0000_1234_5000);

    send(32'h80000037, 3'b011);
    chk("U_neg32",  {32'b0, imm_ext},   64'h0000_0000_8000_0000);
    chk("U_neg64",  imm_ext64,          64'hFFFF_FFFF_8000_0000);

    send(32'h12345678, 3'b110);
    chk("R110_valid", {63'b0, out_valid}, 64'd1);
    chk("R110_imm",   {32'b0, imm_ext},   64'd0);
    chk("R110_ill",   {63'b0, illegal},   64'd1);

    send(32'hFFFFFFFF, 3'b111);
    chk("R111_imm",   imm_ext64,          64'd0);
    chk("R111_ill",   {63'b0, illegal64}, 64'd1);

    send(32'h000FD073, 3'b101);
`ifdef IMM_GEN_ZICSR_EN
    chk("Z_imm",    {32'b0, imm_ext},   64'h0000_0000_0000_001F);
    chk("Z_ill",    {63'b0, illegal},   64'd0);
    chk("Z_imm64",  imm_ext64,          64'h0000_0000_0000_001F);
`else
    chk("Z_imm",    {32'b0, imm_ext},   64'd0);
    chk("Z_ill",    {63'b0, illegal},   64'd1);
`endif

    tick();
    chk("drain_idle", {63'b0, out_valid}, 64'd0);

    // Back-to-back throughput.
    in_valid = 1'b1;
    instr    = 32'h00500093;
    imm_src  = 3'b000;
    tick();
    chk("tp0_imm",   {32'b0, imm_ext},   64'd5);
    instr    = 32'h00600093;
    tick();
    chk("tp1_valid", {63'b0, out_valid}, 64'd1);
    chk("tp1_imm",   {32'b0, imm_ext},   64'd6);
    in_valid = 1'b0;
    tick();
    chk("tp_idle",   {63'b0, out_valid}, 64'd0);

    // Backpressure: three items against a stalled consumer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00100093;
    tick();
    chk("bp1_imm",    {32'b0, imm_ext},  64'd1);
    chk("bp1_ready",  {63'b0, in_ready}, 64'd1);
    instr     = 32'h00200093;
    tick();
    chk("bp2_ready",  {63'b0, in_ready}, 64'd0);
    chk("bp2_hold",   {32'b0, imm_ext},  64'd1);
    instr     = 32'h00300093;
    tick();
    chk("bp3_ready",  {63'b0, in_ready}, 64'd0);
    chk("bp3_hold",   {32'b0, imm_ext},  64'd1);
    chk("bp3_valid",  {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("rec_imm2",   {32'b0, imm_ext},  64'd2);
    chk("rec_ready",  {63'b0, in_ready}, 64'd1);
    tick();
    chk("rec_imm3",   {32'b0, imm_ext},  64'd3);
    chk("rec_valid3", {63'b0, out_valid}, 64'd1);
    in_valid  = 1'b0;
    tick();
    chk("rec_idle",   {63'b0, out_valid}, 64'd0);

    // Asynchronous reset with OUT and SKID both full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00700093;
    tick();
    instr     = 32'h00800093;
    tick();
    in_valid  = 1'b0;
    chk("full_ready", {63'b0, in_ready}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_ready", {63'b0, in_ready},  64'd1);
    chk("arst_imm",   {32'b0, imm_ext},   64'd0);
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_after", {63'b0, out_valid}, 64'd0);
    send(32'h00900093, 3'b000);
    chk("arst_new_valid", {63'b0, out_valid}, 64'd1);
    chk("arst_new_imm",   {32'b0, imm_ext},   64'd9);
    tick();
    chk("arst_new_idle",  {63'b0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
